// File: rtl/spi_xfer_pkg.sv
// spi_xfer_ctrl shared definitions: register map, bit positions, FSM states.
// Optional IRQ output is enabled with SPI_XFER_IRQ_EN.
package spi_xfer_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_RXDATA = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int STS_BUSY     = 0;
    localparam int STS_TX_FULL  = 1;
    localparam int STS_RX_EMPTY = 2;
    localparam int STS_DONE     = 3;
    localparam int STS_OVF      = 4;
    localparam int STS_ERR      = 5;
    localparam int STS_TX_COUNT = 16;

    localparam int CTRL_LEN_LSB = 0;
    localparam int CTRL_LEN_W   = 9;
    localparam int CTRL_START   = 16;
    localparam int CTRL_BUSY    = 16;
    localparam int CTRL_IRQ_EN  = 24;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SEND,
        WAIT_RX,
        CS_HOLD
    } xfer_state_e;

endpackage

// File: rtl/spi_xfer_ctrl_fifo.sv
// spi_byte_fifo: show-ahead 8-bit FIFO with occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module spi_byte_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers and count; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: bus-mapped multi-byte SPI transaction sequencer.
// Define SPI_XFER_IRQ_EN to add the xfer_irq output and CTRL[24] irq_en.
module spi_xfer_ctrl
    import spi_xfer_pkg::*;
#(
    parameter logic [31:0] ADDR          = 32'h0000_0000,
    parameter int          FIFO_DEPTH    = 16,
    parameter int          CS_SETUP_CLKS = 4,
    parameter int          CS_HOLD_CLKS  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_port_ready,
    output logic [31:0] rdata,
    output logic        spi_tx_dv,
    output logic [7:0]  spi_tx_byte,
    input  logic        spi_tx_ready,
    input  logic        spi_rx_dv,
    input  logic [7:0]  spi_rx_byte,
    output logic        spi_cs_n
`ifdef SPI_XFER_IRQ_EN
    ,
    output logic        xfer_irq
`endif
);

    localparam int         CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [8:0] DEPTH_LEN  = 9'(FIFO_DEPTH);
    localparam logic [7:0] SETUP_LOAD = 8'(CS_SETUP_CLKS - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(CS_HOLD_CLKS - 1);

    xfer_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [8:0]  rem_q, rem_d;
    logic        cs_q, cs_d;
    logic        tx_dv_q, tx_dv_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [8:0]  len_q, len_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef SPI_XFER_IRQ_EN
    logic        irq_en_q, irq_en_d;
    logic        irq_q, irq_d;
`endif

    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]       tx_dout, rx_dout;
    logic [CNT_W-1:0] tx_count, rx_count;
    logic [8:0]       tx_cnt9;
    logic             acc, busy;
    logic [3:0]       off;
    logic             ctrl_wr, sts_wr;
    logic             start_req, start_legal;
    logic [8:0]       ctrl_len;
    logic             done_set;
    logic [31:0]      sts_rd, ctrl_rd;
    logic             unused_ok;

    assign busy      = (state_q != IDLE);
    assign tx_cnt9   = 9'(tx_count);
    assign off       = {addr[3:2], 2'b00};
    assign ctrl_len  = wdata[CTRL_LEN_LSB +: CTRL_LEN_W];
    assign acc       = mem_valid && !ready_q
                    && (addr[31:4] == ADDR[31:4]);
    assign unused_ok = ^{addr[1:0], wdata, rx_count, tx_empty};

    spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .push  (tx_push),
        .din   (wdata[7:0]),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .push  (rx_push),
        .din   (spi_rx_byte),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Read-back images of STATUS and CTRL.
    always_comb begin
        sts_rd = '0;
        sts_rd[STS_BUSY]     = busy;
        sts_rd[STS_TX_FULL]  = tx_full;
        sts_rd[STS_RX_EMPTY] = rx_empty;
        sts_rd[STS_DONE]     = done_q;
        sts_rd[STS_OVF]      = ovf_q;
        sts_rd[STS_ERR]      = err_q;
        sts_rd[STS_TX_COUNT +: 9] = tx_cnt9;
        ctrl_rd = '0;
        ctrl_rd[CTRL_LEN_LSB +: CTRL_LEN_W] = len_q;
        ctrl_rd[CTRL_BUSY] = busy;
`ifdef SPI_XFER_IRQ_EN
        ctrl_rd[CTRL_IRQ_EN] = irq_en_q;
`else
        ctrl_rd[CTRL_IRQ_EN] = 1'b0;
`endif
    end

    // Bus decode: one-cycle acknowledge, register side effects.
    always_comb begin
        ready_d     = acc;
        rdata_d     = '0;
        tx_push     = 1'b0;
        rx_pop      = 1'b0;
        ctrl_wr     = 1'b0;
        sts_wr      = 1'b0;
        start_req   = 1'b0;
        len_d       = len_q;
        start_legal = (state_q == IDLE)
                   && (ctrl_len != 9'd0)
                   && (ctrl_len <= DEPTH_LEN)
                   && (tx_cnt9 >= ctrl_len);
        if (acc) begin
            unique case (off)
                OFF_TXDATA: tx_push = wen;
                OFF_RXDATA: begin
                    if (!wen && !rx_empty) begin
                        rx_pop  = 1'b1;
                        rdata_d = {23'b0, 1'b1, rx_dout};
                    end
                end
                OFF_CTRL: begin
                    if (wen) begin
                        ctrl_wr   = 1'b1;
                        len_d     = ctrl_len;
                        start_req = wdata[CTRL_START];
                    end else begin
                        rdata_d = ctrl_rd;
                    end
                end
                default: begin
                    if (wen) sts_wr  = 1'b1;
                    else     rdata_d = sts_rd;
                end
            endcase
        end
    end

    // Transfer sequencer next-state and SPI-side strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        cs_d      = cs_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        done_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_req && start_legal) begin
                    cs_d  = 1'b0;
                    rem_d = ctrl_len;
                    cnt_d = SETUP_LOAD;
                    if (CS_SETUP_CLKS > 1) state_d = CS_SETUP;
                    else                   state_d = SEND;
                end
            end
            CS_SETUP: begin
                if (cnt_q <= 8'd1) state_d = SEND;
                else               cnt_d   = cnt_q - 8'd1;
            end
            SEND: begin
                if (spi_tx_ready) begin
                    tx_pop    = 1'b1;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = tx_dout;
                    rem_d     = rem_q - 9'd1;
                    state_d   = WAIT_RX;
                end
            end
            WAIT_RX: begin
                if (spi_rx_dv) begin
                    rx_push = 1'b1;
                    cnt_d   = HOLD_LOAD;
                    if (rem_q != 9'd0) begin
                        state_d = SEND;
                    end else if (CS_HOLD_CLKS > 1) begin
                        state_d = CS_HOLD;
                    end else begin
                        state_d  = IDLE;
                        cs_d     = 1'b1;
                        done_set = 1'b1;
                    end
                end
            end
            CS_HOLD: begin
                if (cnt_q <= 8'd1) begin
                    state_d  = IDLE;
                    cs_d     = 1'b1;
                    done_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky flags: events set, W1C clears, set wins on collision.
    always_comb begin
        done_d = done_q;
        ovf_d  = ovf_q;
        err_d  = err_q;
        if (sts_wr) begin
            if (wdata[STS_DONE]) done_d = 1'b0;
            if (wdata[STS_OVF])  ovf_d  = 1'b0;
            if (wdata[STS_ERR])  err_d  = 1'b0;
        end
        if (done_set) done_d = 1'b1;
        if (tx_push && tx_full && !tx_pop) ovf_d = 1'b1;
        if (rx_push && rx_full && !rx_pop) ovf_d = 1'b1;
        if (start_req && !start_legal)     err_d = 1'b1;
`ifdef SPI_XFER_IRQ_EN
        irq_en_d = ctrl_wr ? wdata[CTRL_IRQ_EN] : irq_en_q;
        irq_d    = done_q && irq_en_q;
`endif
    end

    // State and output registers; cs_n deasserts asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            cs_q      <= 1'b1;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
`ifdef SPI_XFER_IRQ_EN
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            cs_q      <= cs_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            len_q     <= len_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
`ifdef SPI_XFER_IRQ_EN
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
`endif
        end
    end

    assign mem_port_ready = ready_q;
    assign rdata          = rdata_q;
    assign spi_tx_dv      = tx_dv_q;
    assign spi_tx_byte    = tx_byte_q;
    assign spi_cs_n       = cs_q;
`ifdef SPI_XFER_IRQ_EN
    assign xfer_irq       = irq_q;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl with a loopback SPI master model.
// Build with SPI_XFER_IRQ_EN to exercise the interrupt output as well.
module tb_spi_xfer_ctrl;

    localparam int DEPTH = 16;
    localparam logic [31:0] A_TX  = 32'h0;
    localparam logic [31:0] A_RX  = 32'h4;
    localparam logic [31:0] A_CTL = 32'h8;
    localparam logic [31:0] A_STS = 32'hC;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        ck;
        logic [31:0] exp;
        logic        run;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_port_ready;
    logic [31:0] rdata;
    logic        spi_tx_dv;
    logic [7:0]  spi_tx_byte;
    logic        spi_tx_ready = 1'b1;
    logic        spi_rx_dv = 1'b0;
    logic [7:0]  spi_rx_byte = '0;
    logic        spi_cs_n;
`ifdef SPI_XFER_IRQ_EN
    logic        xfer_irq;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t_fall, t_dv, t_rx, t_rise;
    int n_fall = 0;
    logic [7:0] tx_model[$];
    logic [7:0] rx_model[$];
    logic [31:0] rx_exp;
    vec_t tbl[$];

    spi_xfer_ctrl #(
        .ADDR          (32'h0),
        .FIFO_DEPTH    (DEPTH),
        .CS_SETUP_CLKS (4),
        .CS_HOLD_CLKS  (4)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .mem_valid      (mem_valid),
        .wen            (wen),
        .addr           (addr),
        .wdata          (wdata),
        .mem_port_ready (mem_port_ready),
        .rdata          (rdata),
        .spi_tx_dv      (spi_tx_dv),
        .spi_tx_byte    (spi_tx_byte),
        .spi_tx_ready   (spi_tx_ready),
        .spi_rx_dv      (spi_rx_dv),
        .spi_rx_byte    (spi_rx_byte),
        .spi_cs_n       (spi_cs_n)
`ifdef SPI_XFER_IRQ_EN
        ,
        .xfer_irq       (xfer_irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        @(negedge clk);
        mem_valid = 1'b1;
        wen = w;
        addr = a;
        wdata = d;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (mem_port_ready) begin
                got = 1'b1;
                break;
            end
        end
        rd = rdata;
        mem_valid = 1'b0;
        if (!got) chk("bus_ack", {31'b0, got}, 32'h1);
        if (got && w && a == A_TX && tx_model.size() < DEPTH)
            tx_model.push_back(d[7:0]);
        if (got && !w && a == A_RX) begin
            if (rx_model.size() > 0)
                rx_exp = {23'b0, 1'b1, rx_model.pop_front()};
            else
                rx_exp = 32'h0;
        end
    endtask

    task automatic wait_idle();
        logic [31:0] rd;
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bus(1'b0, A_STS, 32'h0, rd);
            if (!rd[0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_wait", {31'b0, ok}, 32'h1);
    endtask

    task automatic add(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic ck,
                       input logic [31:0] exp, input logic run);
        vec_t v;
        v.w = w; v.a = a; v.d = d;
        v.ck = ck; v.exp = exp; v.run = run;
        tbl.push_back(v);
    endtask

    // DUT-side monitor: cs_n edges and tx byte scoreboard.
    initial begin
        logic cs_prev;
        logic first;
        cs_prev = 1'b1;
        first = 1'b0;
        forever begin
            @(negedge clk);
            if (cs_prev && !spi_cs_n) begin
                t_fall = cyc;
                n_fall++;
                first = 1'b1;
            end
            if (!cs_prev && spi_cs_n) t_rise = cyc;
            cs_prev = spi_cs_n;
            if (spi_tx_dv) begin
                if (first) begin
                    t_dv = cyc;
                    first = 1'b0;
                end
                chk("dv_cs_low", {31'b0, spi_cs_n}, 32'h0);
                if (tx_model.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_extra: got %h expected none",
                             spi_tx_byte);
                end else begin
                    chk("tx_byte", {24'b0, spi_tx_byte},
                        {24'b0, tx_model.pop_front()});
                end
            end
        end
    end

    // Loopback SPI master: echoes each byte three cycles later.
    initial begin
        logic [7:0] b;
        logic abort;
        forever begin
            @(negedge clk);
            spi_rx_dv = 1'b0;
            if (spi_tx_dv && resetn) begin
                b = spi_tx_byte;
                spi_tx_ready = 1'b0;
                abort = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (!resetn) abort = 1'b1;
                end
                if (!abort && resetn) begin
                    spi_rx_byte = b;
                    spi_rx_dv = 1'b1;
                    t_rx = cyc;
                    if (rx_model.size() < DEPTH)
                        rx_model.push_back(b);
                end
                spi_tx_ready = 1'b1;
            end
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic got;

        add(1, A_TX,  32'hC1,       0, 32'h0,          0);
        add(1, A_TX,  32'hBE,       0, 32'h0,          0);
        add(1, A_TX,  32'hEF,       0, 32'h0,          0);
        add(0, A_STS, 32'h0,        1, 32'h0003_0004,  0);
        add(0, A_TX,  32'h0,        1, 32'h0,          0);
        add(0, A_CTL, 32'h0,        1, 32'h0,          0);
        add(1, A_CTL, 32'h0001_0003, 0, 32'h0,         1);
        add(0, A_STS, 32'h0,        1, 32'h0000_0008,  0);
        add(0, A_CTL, 32'h0,        1, 32'h0000_0003,  0);
        add(0, A_RX,  32'h0,        1, 32'h0000_01C1,  0);
        add(0, A_RX,  32'h0,        1, 32'h0000_01BE,  0);
        add(0, A_RX,  32'h0,        1, 32'h0000_01EF,  0);
        add(0, A_RX,  32'h0,        1, 32'h0,          0);
        add(1, A_STS, 32'h8,        0, 32'h0,          0);
        add(0, A_STS, 32'h0,        1, 32'h0000_0004,  0);
        add(1, A_TX,  32'h55,       0, 32'h0,          0);
        add(1, A_CTL, 32'h0001_0002, 0, 32'h0,         0);
        add(0, A_STS, 32'h0,        1, 32'h0001_0024,  0);
        add(0, A_CTL, 32'h0,        1, 32'h0000_0002,  0);
        add(1, A_STS, 32'h20,       0, 32'h0,          0);
        add(0, A_STS, 32'h0,        1, 32'h0001_0004,  0);
        add(1, A_CTL, 32'h0001_0000, 0, 32'h0,         0);
        add(0, A_STS, 32'h0,        1, 32'h0001_0024,  0);
        add(1, A_STS, 32'h20,       0, 32'h0,          0);
        add(1, A_CTL, 32'h0001_0001, 0, 32'h0,         1);
        add(0, A_STS, 32'h0,        1, 32'h0000_0008,  0);
        add(0, A_RX,  32'h0,        1, 32'h0000_0155,  0);
        add(1, A_STS, 32'h38,       0, 32'h0,          0);
        add(0, A_STS, 32'h0,        1, 32'h0000_0004,  0);

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, mem_port_ready}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_dv", {31'b0, spi_tx_dv}, 32'h0);
        chk("rst_byte", {24'b0, spi_tx_byte}, 32'h0);
        chk("rst_cs", {31'b0, spi_cs_n}, 32'h1);
        resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            bus(tbl[i].w, tbl[i].a, tbl[i].d, rd);
            if (tbl[i].ck)
                chk($sformatf("vec%0d", i), rd, tbl[i].exp);
            if (tbl[i].run) begin
                wait_idle();
                chk("setup_clks", t_dv - t_fall, 32'd4);
                chk("hold_clks", t_rise - t_rx, 32'd4);
            end
        end
        chk("cs_falls", n_fall, 32'd2);

        for (int i = 0; i < 17; i++)
            bus(1'b1, A_TX, 32'h10 + i, rd);
        bus(1'b0, A_STS, 32'h0, rd);
        chk("ovf_status", rd, 32'h0010_0016);
        bus(1'b1, A_CTL, 32'h0001_0010, rd);
        wait_idle();
        bus(1'b0, A_STS, 32'h0, rd);
        chk("burst16_status", rd, 32'h0000_0018);
        bus(1'b1, A_STS, 32'h10, rd);
        bus(1'b0, A_STS, 32'h0, rd);
        chk("ovf_cleared", rd, 32'h0000_0008);
        bus(1'b1, A_TX, 32'hAA, rd);
        bus(1'b1, A_CTL, 32'h0001_0001, rd);
        wait_idle();
        bus(1'b0, A_STS, 32'h0, rd);
        chk("rx_drop_ovf", rd, 32'h0000_0018);
        for (int i = 0; i < 16; i++) begin
            bus(1'b0, A_RX, 32'h0, rd);
            chk($sformatf("rx_drain%0d", i), rd,
                32'h100 | (32'h10 + i));
            chk("rx_sb", rd, rx_exp);
        end
        bus(1'b0, A_RX, 32'h0, rd);
        chk("rx_after_drain", rd, 32'h0);
        bus(1'b1, A_STS, 32'h38, rd);

        @(negedge clk);
        mem_valid = 1'b1;
        wen = 1'b0;
        addr = 32'h10;
        got = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (mem_port_ready) got = 1'b1;
        end
        mem_valid = 1'b0;
        chk("oob_noack", {31'b0, got}, 32'h0);

        bus(1'b1, A_TX, 32'h61, rd);
        bus(1'b1, A_TX, 32'h62, rd);
        bus(1'b1, A_CTL, 32'h0001_0002, rd);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (spi_tx_dv) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst_dv_seen", {31'b0, got}, 32'h1);
        @(negedge clk);
        chk("pre_rst_cs", {31'b0, spi_cs_n}, 32'h0);
        resetn = 1'b0;
        #1;
        chk("async_cs", {31'b0, spi_cs_n}, 32'h1);
        tx_model.delete();
        rx_model.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        bus(1'b0, A_STS, 32'h0, rd);
        chk("post_rst_sts", rd, 32'h0000_0004);
        bus(1'b0, A_CTL, 32'h0, rd);
        chk("post_rst_ctl", rd, 32'h0);

`ifdef SPI_XFER_IRQ_EN
        bus(1'b1, A_TX, 32'h77, rd);
        bus(1'b1, A_CTL, 32'h0101_0001, rd);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (spi_cs_n) begin
                got = 1'b1;
                break;
            end
        end
        chk("irq_cs_rise", {31'b0, got}, 32'h1);
        chk("irq_lag", {31'b0, xfer_irq}, 32'h0);
        @(negedge clk);
        chk("irq_rise", {31'b0, xfer_irq}, 32'h1);
        bus(1'b0, A_CTL, 32'h0, rd);
        chk("irq_ctl", rd, 32'h0100_0001);
        bus(1'b0, A_RX, 32'h0, rd);
        chk("irq_rx", rd, 32'h0000_0177);
        bus(1'b1, A_STS, 32'h8, rd);
        repeat (2) @(negedge clk);
        chk("irq_fall", {31'b0, xfer_irq}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
